// File: rtl/counter_mod.sv
// Programmable-range up/down counter with run-time step, wrap or saturate
// at the range boundary, a registered wrap pulse and a sticky clip flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   load_n     synchronous load, active-low (beats ce)
//   ce         count enable
//   up_down    1 = count up, 0 = count down
//   sat_en     1 = saturate at the range ends, 0 = wrap
//   step       amount added/subtracted per enabled cycle
//   limit      inclusive upper bound of the range [0, limit]
//   data_load  value loaded when load_n is low (clamped to limit)
//   count_out  registered count
//   max_count  count_out == limit (combinational)
//   zero       count_out == 0 (combinational)
//   wrap_pulse registered, high for the cycle after each wrap
//   sat_flag   registered, sticky; set whenever a result is clipped
module counter_mod #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_n,
  input  logic              ce,
  input  logic              up_down,
  input  logic              sat_en,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  data_load,
  output logic [WIDTH-1:0]  count_out,
  output logic              max_count,
  output logic              zero,
  output logic              wrap_pulse,
  output logic              sat_flag
);

  // One guard bit above the wider of count and step so that
  // count+step and count+R never overflow.
  localparam int EW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;

  logic [EW-1:0] cnt_x, lim_x, stp_x, rng_x;
  logic [EW-1:0] sum_x, dif_x, wup_x, wdn_x;
  logic          step_big;
  logic          clip;

  assign cnt_x = EW'(count_q);
  assign lim_x = EW'(limit);
  assign stp_x = EW'(step);
  assign rng_x = lim_x + EW'(1);

  assign sum_x = cnt_x + stp_x;
  assign dif_x = cnt_x - stp_x;
  assign wup_x = sum_x - rng_x;
  assign wdn_x = cnt_x + rng_x - stp_x;

  // A step wider than the whole range cannot wrap meaningfully;
  // such a cycle behaves as saturate mode.
  assign step_big = stp_x > rng_x;
  assign clip     = sat_en | step_big;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    if (!load_n) begin
      if (data_load <= limit) begin
        count_d = data_load;
        sat_d   = 1'b0;
      end else begin
        count_d = limit;
        sat_d   = 1'b1;
      end
    end else if (ce) begin
      if (count_q > limit) begin
        // limit was lowered under a running count
        count_d = limit;
        sat_d   = 1'b1;
      end else if (stp_x != '0) begin
        if (up_down) begin
          if (sum_x <= lim_x) begin
            count_d = WIDTH'(sum_x);
          end else if (clip) begin
            count_d = limit;
            sat_d   = 1'b1;
          end else begin
            count_d = WIDTH'(wup_x);
            wrap_d  = 1'b1;
          end
        end else begin
          if (stp_x <= cnt_x) begin
            count_d = WIDTH'(dif_x);
          end else if (clip) begin
            count_d = '0;
            sat_d   = 1'b1;
          end else begin
            count_d = WIDTH'(wdn_x);
            wrap_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count_out  = count_q;
  assign max_count  = (count_q == limit);
  assign zero       = (count_q == '0);
  assign wrap_pulse = wrap_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_counter_mod.sv
// Scoreboard bench for counter_mod: a behavioural model pushes the
// expected state when stimulus is driven; it is popped at the next negedge.
module tb_counter_mod;

  localparam int W  = 4;
  localparam int SW = 2;

  logic          clk;
  logic          rst;
  logic          load_n;
  logic          ce;
  logic          up_down;
  logic          sat_en;
  logic [SW-1:0] step;
  logic [W-1:0]  limit;
  logic [W-1:0]  data_load;
  logic [W-1:0]  count_out;
  logic          max_count;
  logic          zero;
  logic          wrap_pulse;
  logic          sat_flag;

  counter_mod #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk(clk),
    .rst(rst),
    .load_n(load_n),
    .ce(ce),
    .up_down(up_down),
    .sat_en(sat_en),
    .step(step),
    .limit(limit),
    .data_load(data_load),
    .count_out(count_out),
    .max_count(max_count),
    .zero(zero),
    .wrap_pulse(wrap_pulse),
    .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit wrap;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int m_cnt;
  bit m_wrap;
  bit m_sat;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int c, l, s, r;
    c = m_cnt;
    l = int'(limit);
    s = int'(step);
    r = l + 1;
    m_wrap = 1'b0;
    if (!load_n) begin
      if (int'(data_load) <= l) begin
        m_cnt = int'(data_load);
        m_sat = 1'b0;
      end else begin
        m_cnt = l;
        m_sat = 1'b1;
      end
    end else if (ce) begin
      if (c > l) begin
        m_cnt = l;
        m_sat = 1'b1;
      end else if (s != 0) begin
        if (up_down) begin
          if (c + s <= l) m_cnt = c + s;
          else if (sat_en || s > r) begin
            m_cnt = l;
            m_sat = 1'b1;
          end else begin
            m_cnt  = c + s - r;
            m_wrap = 1'b1;
          end
        end else begin
          if (s <= c) m_cnt = c - s;
          else if (sat_en || s > r) begin
            m_cnt = 0;
            m_sat = 1'b1;
          end else begin
            m_cnt  = c + r - s;
            m_wrap = 1'b1;
          end
        end
      end
    end
  endtask

  // Called just after a negedge; returns at the following negedge.
  task automatic cycle(input bit ld_n, input bit en, input bit ud,
                       input bit se, input int st, input int lim,
                       input int dl);
    exp_t e;
    load_n    = ld_n;
    ce        = en;
    up_down   = ud;
    sat_en    = se;
    step      = SW'(st);
    limit     = W'(lim);
    data_load = W'(dl);
    model_step();
    e.cnt  = m_cnt;
    e.wrap = m_wrap;
    e.sat  = m_sat;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("count", int'(count_out), e.cnt);
      check("wrap", int'(wrap_pulse), int'(e.wrap));
      check("sat", int'(sat_flag), int'(e.sat));
      check("max", int'(max_count), int'(e.cnt == int'(limit)));
      check("zero", int'(zero), int'(e.cnt == 0));
    end
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_count", int'(count_out), 0);
    check("rst_zero", int'(zero), 1);
    check("rst_wrap", int'(wrap_pulse), 0);
    check("rst_sat", int'(sat_flag), 0);
    check("rst_max", int'(max_count), int'(limit == '0));
    @(negedge clk);
    rst    = 1'b0;
    m_cnt  = 0;
    m_wrap = 1'b0;
    m_sat  = 1'b0;
    exp_q.delete();
  endtask

  int wseq[5] = '{1, 4, 7, 0, 3};
  bit wpul[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  int dseq[3] = '{1, 0, 0};

  initial begin
    rst       = 1'b1;
    load_n    = 1'b1;
    ce        = 1'b0;
    up_down   = 1'b1;
    sat_en    = 1'b0;
    step      = '0;
    limit     = '0;
    data_load = '0;
    m_cnt     = 0;
    m_wrap    = 1'b0;
    m_sat     = 1'b0;
    #1;
    check("init_count", int'(count_out), 0);
    check("init_max", int'(max_count), 1);
    check("init_zero", int'(zero), 1);
    @(negedge clk);
    rst = 1'b0;

    // up wrap, limit 9, step 3
    cycle(0, 0, 1, 0, 3, 9, 8);
    check("uw_load", int'(count_out), 8);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 1, 0, 3, 9, 0);
      check("uw_seq", int'(count_out), wseq[i]);
      check("uw_pulse", int'(wrap_pulse), int'(wpul[i]));
      check("uw_sat", int'(sat_flag), 0);
    end

    // down saturate, limit 15, step 2
    cycle(0, 0, 0, 1, 2, 15, 3);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 1, 2, 15, 0);
      check("ds_seq", int'(count_out), dseq[i]);
      check("ds_sat", int'(sat_flag), int'(i > 0));
      check("ds_wrap", int'(wrap_pulse), 0);
    end

    // load priority over ce, clamp, then in-range load clears flag
    cycle(0, 1, 1, 0, 1, 9, 12);
    check("lc_count", int'(count_out), 9);
    check("lc_max", int'(max_count), 1);
    check("lc_sat", int'(sat_flag), 1);
    cycle(0, 1, 1, 0, 1, 9, 5);
    check("ld_count", int'(count_out), 5);
    check("ld_sat", int'(sat_flag), 0);

    // limit lowered below a running count
    cycle(0, 0, 1, 0, 1, 15, 12);
    cycle(1, 1, 1, 0, 1, 5, 0);
    check("ll_count", int'(count_out), 5);
    check("ll_sat", int'(sat_flag), 1);
    check("ll_wrap", int'(wrap_pulse), 0);
    cycle(1, 1, 1, 0, 1, 5, 0);
    check("ll_wcount", int'(count_out), 0);
    check("ll_wpulse", int'(wrap_pulse), 1);

    // step larger than range in wrap mode clips instead of wrapping
    cycle(0, 0, 1, 0, 3, 1, 1);
    cycle(1, 1, 1, 0, 3, 1, 0);
    check("big_count", int'(count_out), 1);
    check("big_sat", int'(sat_flag), 1);
    check("big_wrap", int'(wrap_pulse), 0);

    // async reset mid-count at 7
    cycle(0, 0, 1, 0, 1, 9, 7);
    check("ar_pre", int'(count_out), 7);
    pulse_reset();

    // random regression
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(99) < 2) begin
        pulse_reset();
      end else begin
        cycle(($urandom_range(99) >= 12),
              ($urandom_range(99) < 80),
              1'($urandom_range(1)),
              1'($urandom_range(1)),
              int'($urandom_range(3)),
              ($urandom_range(9) < 8) ? int'(limit) : int'($urandom_range(15)),
              int'($urandom_range(15)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
